// File: rtl/start_counter_bank.sv
// start_counter_bank: per-channel start/stop up/down counters posting terminal events on one valid/ready port.
// Optional coherent count snapshot when COUNTER_BANK_SNAPSHOT_EN is defined.
module start_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic                      cfg_we,
  input  logic [CHW-1:0]            cfg_chan,
  input  logic [WIDTH-1:0]          cfg_limit,
  input  logic                      cfg_down,
  input  logic                      cfg_reload,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      done_valid,
  output logic [CHW-1:0]            done_chan,
  input  logic                      done_ready
`ifdef COUNTER_BANK_SNAPSHOT_EN
  ,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] snap_count
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    count_d [CHANNELS];
  logic [WIDTH-1:0]    limit_q [CHANNELS];
  logic [WIDTH-1:0]    limit_d [CHANNELS];
  logic [CHANNELS-1:0] down_q, down_d;
  logic [CHANNELS-1:0] reload_q, reload_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] overrun_q, overrun_d;
  logic [CHANNELS-1:0] hit, clr;
  logic                done_valid_q, done_valid_d;
  logic [CHW-1:0]      done_chan_q, done_chan_d;
  logic                found;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    limit_d      = limit_q;
    down_d       = down_q;
    reload_d     = reload_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    hit          = '0;
    clr          = '0;
    done_valid_d = 1'b0;
    done_chan_d  = '0;
    found        = 1'b0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      clr[i] = done_valid_q && done_ready && (done_chan_q == CHW'(i));

      // Priority: stop, then start/restart, then terminal check or step.
      if (stop[i]) begin
        state_d[i] = S_IDLE;
      end else if (start[i]) begin
        state_d[i]   = S_RUN;
        count_d[i]   = down_q[i] ? limit_q[i] : '0;
        overrun_d[i] = 1'b0;
      end else if (state_q[i] == S_RUN) begin
        if (count_q[i] == (down_q[i] ? '0 : limit_q[i])) begin
          hit[i] = 1'b1;
          if (reload_q[i]) count_d[i] = down_q[i] ? limit_q[i] : '0;
          else             state_d[i] = S_IDLE;
        end else begin
          count_d[i] = down_q[i] ? count_q[i] - WIDTH'(1) : count_q[i] + WIDTH'(1);
        end
      end

      if (clr[i]) pending_d[i] = 1'b0;
      if (hit[i]) begin
        if (pending_q[i] && !clr[i]) overrun_d[i] = 1'b1;
        pending_d[i] = 1'b1;
      end

      // Out-of-range cfg_chan never matches any index, so it is dropped here.
      if (cfg_we && (cfg_chan == CHW'(i)) && (state_q[i] == S_IDLE)) begin
        limit_d[i]  = cfg_limit;
        down_d[i]   = cfg_down;
        reload_d[i] = cfg_reload;
      end
    end

    done_valid_d = |pending_d;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pending_d[i] && !found) begin
        done_chan_d = CHW'(i);
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
        limit_q[i] <= '1;
      end
      down_q       <= '0;
      reload_q     <= '0;
      pending_q    <= '0;
      overrun_q    <= '0;
      done_valid_q <= 1'b0;
      done_chan_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      limit_q      <= limit_d;
      down_q       <= down_d;
      reload_q     <= reload_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      done_valid_q <= done_valid_d;
      done_chan_q  <= done_chan_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign count[g*WIDTH +: WIDTH] = count_q[g];
    assign busy[g]                 = (state_q[g] == S_RUN);
  end

  assign overrun    = overrun_q;
  assign done_valid = done_valid_q;
  assign done_chan  = done_chan_q;

`ifdef COUNTER_BANK_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] snap_q;

  always_ff @(posedge clk) begin
    if (!reset)    snap_q <= '0;
    else if (snap) snap_q <= count;
  end

  assign snap_count = snap_q;
`endif

endmodule

// File: doc/start_counter_bank.md
# start_counter_bank

Multi-channel, parametrised start/stop counter bank; the next generation of the single 8-bit start-triggered counter used alongside the `my_svi` interface blocks. Each channel counts up or down to a programmable limit, either one-shot or auto-reload, and posts terminal-count events through a single valid/ready event port with fixed-priority arbitration. It sits between the control registers and the consumers that previously watched one raw `count` bus.

## Interface
Parameters:
- `WIDTH`, 8, counter width per channel (≥2)
- `CHANNELS`, 4, number of independent channels (1..32)
- `CHW`, `$clog2(CHANNELS)` (min 1), derived; channel index width, do not override

Ports:
- `clk` in 1 — sole clock, all logic rising-edge
- `reset` in 1 — synchronous, active-low; sampled on `clk`
- `start` in CHANNELS — per-channel start/restart pulse
- `stop` in CHANNELS — per-channel abort pulse
- `cfg_we` in 1 — configuration write strobe
- `cfg_chan` in CHW — channel addressed by `cfg_we`
- `cfg_limit` in WIDTH — terminal limit
- `cfg_down` in 1 — 1 = count down from limit to 0, 0 = count up from 0 to limit
- `cfg_reload` in 1 — 1 = auto-reload, 0 = one-shot
- `count` out CHANNELS*WIDTH — channel i at bits [i*WIDTH +: WIDTH]
- `busy` out CHANNELS — channel in RUN
- `overrun` out CHANNELS — sticky: terminal event lost
- `done_valid` out 1 — at least one event pending
- `done_chan` out CHW — index of event presented
- `done_ready` in 1 — consumer accepts event

## Operation
- Per-channel state: IDLE, RUN. Config regs per channel: limit, down, reload.
- Config write: `cfg_we` stores fields into channel `cfg_chan` if that channel's `busy`=0; ignored if busy=1 or `cfg_chan` ≥ CHANNELS.
- IDLE → RUN on `start[i]`: count loads init (0 if up, limit if down); `overrun[i]` clears.
- RUN, each cycle: if count == term (limit if up, 0 if down) → raise event; then reload=1: count ← init, stay RUN; reload=0: count holds, → IDLE. Otherwise count steps ±1.
- `start[i]` in RUN: restart, count ← init, no event.
- `stop[i]`: → IDLE, count holds, no event. `stop` and `start` same cycle: stop wins.
- Events: `pending[i]` set on terminal. Terminal while `pending[i]` already set and not being cleared that cycle → `overrun[i]` ← 1, pending stays 1.
- Arbitration: `done_valid` = OR(pending); `done_chan` = lowest-index pending channel. `done_valid & done_ready` clears that bit. Clear and new terminal on same channel same cycle: pending stays 1, no overrun.
- Count arithmetic modulo 2^WIDTH; never passes term since term is compared each cycle.

## Timing
- Reset (`reset`=0 at edge): all outputs 0 (`count`, `busy`, `overrun`, `done_valid`, `done_chan`), pending 0, state IDLE, limit all-ones, down 0, reload 0. Mid-operation reset discards pending events and config.
- `start` at edge t → `busy`=1, `count`=init visible after t.
- Up, limit L, one-shot: `count` shows 0..L, L+1 cycles in RUN; `done_valid` rises the cycle after count==L is first visible, same edge `busy` falls.
- Reload period L+1 cycles; limit 0 → event every cycle.
- `done_valid`/`done_chan` registered; held stable until accepted unless a lower-index event arrives (no stability guarantee across priority change).

## Configuration
- `COUNTER_BANK_SNAPSHOT_EN` defined: adds input `snap` (1) and output `snap_count` (CHANNELS*WIDTH); on `snap`, all counts captured coherently in one cycle, visible next cycle; reset value 0.
- Undefined: ports and snapshot register absent; all other behaviour identical.

## Test plan
- Reset then channel 0 up, limit 5, one-shot, `start[0]` → `count[0]` 0..5, `busy[0]` low after 6 cycles, one event `done_chan`=0 accepted with `done_ready`=1.
- Channel 1 down, limit 3, reload, `done_ready`=0 → events at 4-cycle period; second terminal sets `overrun[1]`=1; `start[1]` clears it.
- Channels 2 and 3 terminal same cycle, `done_ready`=1 → `done_chan`=2 then 3 on consecutive cycles.
- `start[0]`+`stop[0]` same cycle in RUN → IDLE, count held, no event; `cfg_we` to busy channel → limit unchanged.
- `reset` low mid-count with pending events → next cycle all outputs 0, limits all-ones.
- With `COUNTER_BANK_SNAPSHOT_EN`: `snap` while channels run → `snap_count` equals `count` of pulse cycle, held until next `snap`.
